// File: rtl/mirfak_pkg.sv
// Shared encodings for the mirfak instruction/data Wishbone arbiter.
package mirfak_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_IGNT = 3'b010,
    ST_DGNT = 3'b100
  } arb_state_e;

  typedef enum logic {
    OWN_INSTR = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/mirfak_arb_timeout.sv
// Bus watchdog: counts stalled owner cycles and pulses expire on the
// TIMEOUT-th consecutive stalled cycle.
module mirfak_arb_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic stall_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] TERM = W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clear_i) begin
      cnt <= '0;
    end else if (stall_i) begin
      cnt <= cnt + W'(1);
    end
  end

  // Expire fires on the stalled cycle itself, so err reaches the owner without extra delay.
  assign expire_o = stall_i & (cnt == TERM);

endmodule

// File: rtl/mirfak_wb_arbiter.sv
// Two-master Wishbone arbiter (instruction/data) sharing one bus, registered grant.
// Optional watchdog compiled in when ARBITER_TIMEOUT_EN is defined.
module mirfak_wb_arbiter
  import mirfak_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] iwb_addr_i,
  input  logic        iwb_cyc_i,
  input  logic        iwb_stb_i,
  output logic        iwb_ack_o,
  output logic        iwb_err_o,
  input  logic [31:0] dwb_addr_i,
  input  logic [31:0] dwb_dat_i,
  input  logic [3:0]  dwb_sel_i,
  input  logic        dwb_we_i,
  input  logic        dwb_cyc_i,
  input  logic        dwb_stb_i,
  output logic        dwb_ack_o,
  output logic        dwb_err_o,
  output logic [31:0] wbm_addr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  // state | meaning
  // IDLE  | no owner; arbitrate pending requests
  // IGNT  | instruction master owns the bus
  // DGNT  | data master owns the bus

  arb_state_e state, state_nxt;
  owner_e     last, last_nxt;
  logic       ireq, dreq, own_cyc, expire, bus_done;

  assign ireq     = iwb_cyc_i & iwb_stb_i;
  assign dreq     = dwb_cyc_i & dwb_stb_i;
  assign own_cyc  = (state == ST_IGNT) ? iwb_cyc_i :
                    (state == ST_DGNT) ? dwb_cyc_i : 1'b0;
  assign bus_done = wbm_ack_i | wbm_err_i | expire;

`ifdef ARBITER_TIMEOUT_EN
  logic own_stb, wd_stall, wd_clear;

  assign own_stb  = (state == ST_IGNT) ? iwb_stb_i :
                    (state == ST_DGNT) ? dwb_stb_i : 1'b0;
  assign wd_stall = own_cyc & own_stb & ~wbm_ack_i & ~wbm_err_i;
  assign wd_clear = (state == ST_IDLE) | ~own_cyc | wbm_ack_i | wbm_err_i;

  mirfak_arb_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (wd_clear),
    .stall_i (wd_stall),
    .expire_o(expire)
  );
`else
  logic unused_timeout;

  assign expire         = 1'b0;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      last  <= OWN_INSTR;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    wbm_addr_o = '0;
    wbm_dat_o  = '0;
    wbm_sel_o  = '0;
    wbm_we_o   = 1'b0;
    wbm_cyc_o  = 1'b0;
    wbm_stb_o  = 1'b0;
    iwb_ack_o  = 1'b0;
    iwb_err_o  = 1'b0;
    dwb_ack_o  = 1'b0;
    dwb_err_o  = 1'b0;
    state_nxt  = state;
    last_nxt   = last;

    case (state)
      ST_IDLE: begin
        if (ireq && dreq) begin
          state_nxt = (last == OWN_INSTR) ? ST_DGNT : ST_IGNT;
        end else if (ireq) begin
          state_nxt = ST_IGNT;
        end else if (dreq) begin
          state_nxt = ST_DGNT;
        end
      end
      ST_IGNT: begin
        wbm_addr_o = iwb_addr_i;
        wbm_sel_o  = SEL_ALL;
        wbm_cyc_o  = iwb_cyc_i & ~expire;
        wbm_stb_o  = iwb_stb_i & ~expire;
        // A response racing a dropped cyc belongs to an aborted fetch.
        iwb_ack_o  = iwb_cyc_i & wbm_ack_i;
        iwb_err_o  = (iwb_cyc_i & wbm_err_i) | expire;
        if (!iwb_cyc_i) begin
          state_nxt = ST_IDLE;
        end else if (bus_done) begin
          state_nxt = ST_IDLE;
          last_nxt  = OWN_INSTR;
        end
      end
      ST_DGNT: begin
        wbm_addr_o = dwb_addr_i;
        wbm_dat_o  = dwb_dat_i;
        wbm_sel_o  = dwb_sel_i;
        wbm_we_o   = dwb_we_i;
        wbm_cyc_o  = dwb_cyc_i & ~expire;
        wbm_stb_o  = dwb_stb_i & ~expire;
        dwb_ack_o  = dwb_cyc_i & wbm_ack_i;
        dwb_err_o  = (dwb_cyc_i & wbm_err_i) | expire;
        if (!dwb_cyc_i) begin
          state_nxt = ST_IDLE;
        end else if (bus_done) begin
          state_nxt = ST_IDLE;
          last_nxt  = OWN_DATA;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mirfak_wb_arbiter.sv
// Bench for mirfak_wb_arbiter: directed scenarios plus random traffic,
// every cycle compared against a transaction-level ownership model.
module tb_mirfak_wb_arbiter;

  localparam int TB_TO = 4;

  logic        clk, rst_n;
  logic [31:0] iwb_addr, dwb_addr, dwb_dat, wbm_addr, wbm_dat;
  logic [3:0]  dwb_sel, wbm_sel;
  logic        iwb_cyc, iwb_stb, iwb_ack, iwb_err;
  logic        dwb_we, dwb_cyc, dwb_stb, dwb_ack, dwb_err;
  logic        wbm_we, wbm_cyc, wbm_stb, wbm_ack, wbm_err;

  mirfak_wb_arbiter #(.TIMEOUT(TB_TO)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .iwb_addr_i(iwb_addr),
    .iwb_cyc_i (iwb_cyc),
    .iwb_stb_i (iwb_stb),
    .iwb_ack_o (iwb_ack),
    .iwb_err_o (iwb_err),
    .dwb_addr_i(dwb_addr),
    .dwb_dat_i (dwb_dat),
    .dwb_sel_i (dwb_sel),
    .dwb_we_i  (dwb_we),
    .dwb_cyc_i (dwb_cyc),
    .dwb_stb_i (dwb_stb),
    .dwb_ack_o (dwb_ack),
    .dwb_err_o (dwb_err),
    .wbm_addr_o(wbm_addr),
    .wbm_dat_o (wbm_dat),
    .wbm_sel_o (wbm_sel),
    .wbm_we_o  (wbm_we),
    .wbm_cyc_o (wbm_cyc),
    .wbm_stb_o (wbm_stb),
    .wbm_ack_i (wbm_ack),
    .wbm_err_i (wbm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: who owns the bus (0 none, 1 instr, 2 data), who was served last
  // (0 instr, 1 data) and how many stalled cycles the owner has accumulated.
  int m_own = 0;
  int m_last = 0;
  int m_wd = 0;
  bit chk_en = 1'b0;

  function automatic bit o_cyc();
    return (m_own == 1) ? iwb_cyc : (m_own == 2) ? dwb_cyc : 1'b0;
  endfunction

  function automatic bit o_stb();
    return (m_own == 1) ? iwb_stb : (m_own == 2) ? dwb_stb : 1'b0;
  endfunction

  function automatic bit to_hit();
`ifdef ARBITER_TIMEOUT_EN
    return (m_own != 0) && o_cyc() && o_stb() && !wbm_ack && !wbm_err && (m_wd == TB_TO - 1);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit oc, to, ir, dr;
    if (!rst_n) begin
      m_own = 0; m_last = 0; m_wd = 0; chk_en = 1'b1;
    end else begin
      oc = o_cyc();
      to = to_hit();
      ir = iwb_cyc && iwb_stb;
      dr = dwb_cyc && dwb_stb;
      if (m_own == 0) begin
        m_wd = 0;
        if (ir && dr)  m_own = (m_last == 0) ? 2 : 1;
        else if (ir)   m_own = 1;
        else if (dr)   m_own = 2;
      end else if (!oc) begin
        m_own = 0; m_wd = 0;
      end else if (wbm_ack || wbm_err || to) begin
        m_last = m_own - 1; m_own = 0; m_wd = 0;
      end else if (o_stb()) begin
        m_wd++;
      end
    end
  end

  int n_iack, n_dack, n_ierr, n_derr, n_wcyc;
  int gq[$];

  always @(negedge clk) begin
    bit oc, to;
    if (chk_en) begin
      oc = o_cyc();
      to = to_hit();
      check_val("wbm_cyc", 32'(wbm_cyc), 32'(oc && !to));
      check_val("wbm_stb", 32'(wbm_stb), 32'(o_stb() && !to));
      check_val("wbm_addr", wbm_addr, (m_own == 1) ? iwb_addr : (m_own == 2) ? dwb_addr : 32'h0);
      check_val("wbm_dat", wbm_dat, (m_own == 2) ? dwb_dat : 32'h0);
      check_val("wbm_sel", 32'(wbm_sel), (m_own == 1) ? 32'hF : (m_own == 2) ? 32'(dwb_sel) : 32'h0);
      check_val("wbm_we", 32'(wbm_we), 32'((m_own == 2) && dwb_we));
      check_val("iwb_ack", 32'(iwb_ack), 32'((m_own == 1) && oc && wbm_ack));
      check_val("iwb_err", 32'(iwb_err), 32'((m_own == 1) && ((oc && wbm_err) || to)));
      check_val("dwb_ack", 32'(dwb_ack), 32'((m_own == 2) && oc && wbm_ack));
      check_val("dwb_err", 32'(dwb_err), 32'((m_own == 2) && ((oc && wbm_err) || to)));
      if (iwb_ack) begin n_iack++; gq.push_back(0); end
      if (dwb_ack) begin n_dack++; gq.push_back(1); end
      if (iwb_err) n_ierr++;
      if (dwb_err) n_derr++;
      if (wbm_cyc) n_wcyc++;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    n_iack = 0; n_dack = 0; n_ierr = 0; n_derr = 0; n_wcyc = 0;
    gq.delete();
  endtask

  task automatic idle_in();
    iwb_cyc = 0; iwb_stb = 0; dwb_cyc = 0; dwb_stb = 0; dwb_we = 0;
    wbm_ack = 0; wbm_err = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step(2);
    rst_n = 1;
  endtask

  initial begin
    iwb_addr = 32'h0000_1000; dwb_addr = 32'h0; dwb_dat = 32'h0; dwb_sel = 4'h0;
    idle_in();
    clr_cnt();
    do_reset();

    // reset state
    #1;
    check_val("rst_cyc", 32'(wbm_cyc), 32'h0);
    check_val("rst_acks", 32'({iwb_ack, iwb_err, dwb_ack, dwb_err}), 32'h0);

    // data-only write, ack on second bus cycle
    clr_cnt();
    dwb_addr = 32'h8000_0100; dwb_dat = 32'hA5A5_1234; dwb_sel = 4'h3; dwb_we = 1;
    dwb_cyc = 1; dwb_stb = 1;
    #1 check_val("d_req_idle", 32'(wbm_cyc), 32'h0);
    step();
    #1 check_val("d_grant_lat", 32'(wbm_cyc), 32'h1);
    step();
    wbm_ack = 1;
    step();
    idle_in();
    step();
    check_val("d_ack_pulses", 32'(n_dack), 32'h1);
    check_val("d_iack_none", 32'(n_iack), 32'h0);

    // ties from reset alternate D, I, D, I...
    do_reset();
    clr_cnt();
    iwb_cyc = 1; iwb_stb = 1; dwb_cyc = 1; dwb_stb = 1; dwb_we = 0;
    wbm_ack = 1;
    step(12);
    idle_in();
    step();
    check_val("tie_count", 32'(gq.size()), 32'd6);
    for (int i = 0; i < gq.size(); i++)
      check_val($sformatf("tie_order%0d", i), 32'(gq[i]), 32'((i % 2 == 0) ? 1 : 0));

    // instruction fetch abort followed by a late ack
    clr_cnt();
    iwb_addr = 32'h0000_2040; iwb_cyc = 1; iwb_stb = 1;
    step();
    #1 check_val("abort_grant", 32'(wbm_cyc), 32'h1);
    step();
    iwb_cyc = 0; iwb_stb = 0; wbm_ack = 1;
    #1 check_val("abort_cyc_drop", 32'(wbm_cyc), 32'h0);
    step();
    step();
    idle_in();
    step();
    check_val("abort_no_ack", 32'(n_iack), 32'h0);
    check_val("abort_cyc_cycles", 32'(n_wcyc), 32'h1);

    // reset in the middle of a data transfer
    clr_cnt();
    dwb_cyc = 1; dwb_stb = 1;
    step();
    rst_n = 0;
    step();
    rst_n = 1; dwb_cyc = 0; dwb_stb = 0; wbm_ack = 1;
    #1 check_val("rst_mid_cyc", 32'(wbm_cyc), 32'h0);
    step();
    idle_in();
    step();
    check_val("rst_mid_no_ack", 32'(n_dack), 32'h0);

    // error response on a data transfer
    clr_cnt();
    dwb_cyc = 1; dwb_stb = 1;
    step();
    wbm_err = 1;
    #1 check_val("derr_pulse", 32'(dwb_err), 32'h1);
    check_val("derr_no_ack", 32'(dwb_ack), 32'h0);
    step();
    wbm_err = 0;
    #1 check_val("derr_to_idle", 32'(wbm_cyc), 32'h0);
    idle_in();
    step(2);
    check_val("derr_count", 32'(n_derr), 32'h1);

`ifdef ARBITER_TIMEOUT_EN
    // watchdog with a silent slave, instruction master waiting behind
    do_reset();
    clr_cnt();
    iwb_addr = 32'h0000_3000;
    dwb_cyc = 1; dwb_stb = 1;
    step();
    iwb_cyc = 1; iwb_stb = 1;
    step(2);
    #1 check_val("to_not_early", 32'(dwb_err), 32'h0);
    step();
    #1 check_val("to_err", 32'(dwb_err), 32'h1);
    check_val("to_cyc_low", 32'(wbm_cyc), 32'h0);
    step();
    step();
    #1 check_val("to_other_grant", wbm_addr, 32'h0000_3000);
    check_val("to_other_cyc", 32'(wbm_cyc), 32'h1);
    idle_in();
    step(2);
    check_val("to_err_count", 32'(n_derr), 32'h1);
`endif

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst_n    = ($urandom_range(0, 199) != 0);
      iwb_cyc  = ($urandom_range(0, 3) != 0);
      iwb_stb  = ($urandom_range(0, 3) != 0);
      iwb_addr = $urandom;
      dwb_cyc  = ($urandom_range(0, 3) != 0);
      dwb_stb  = ($urandom_range(0, 3) != 0);
      dwb_addr = $urandom;
      dwb_dat  = $urandom;
      dwb_sel  = 4'($urandom);
      dwb_we   = 1'($urandom);
      wbm_ack  = ($urandom_range(0, 3) == 0);
      wbm_err  = ($urandom_range(0, 15) == 0);
      step();
    end
    rst_n = 1;
    idle_in();
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mirfak_wb_arbiter.md
MIRFAK_WB_ARBITER -- requirements
Module: mirfak_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: cycles the watchdog waits for ack/err before aborting (1..65535).
REQ-002 clk_i  input  1  one clock; all state updates on its rising edge.
REQ-003 rst_ni  input  1  reset, synchronous and active-low.
REQ-004 iwb_addr_i  input  32  instruction master address.
REQ-005 iwb_cyc_i / iwb_stb_i  input  1 each  instruction master cycle/strobe.
REQ-006 iwb_ack_o / iwb_err_o  output  1 each  instruction master ack/error.
REQ-007 dwb_addr_i / dwb_dat_i  input  32 each  data master address / write data.
REQ-008 dwb_sel_i  input  4  data master byte select.
REQ-009 dwb_we_i / dwb_cyc_i / dwb_stb_i  input  1 each  data master write-enable/cycle/strobe.
REQ-010 dwb_ack_o / dwb_err_o  output  1 each  data master ack/error.
REQ-011 wbm_addr_o / wbm_dat_o  output  32 each  shared bus address / write data.
REQ-012 wbm_sel_o  output  4  shared bus byte select; 4'hF on instruction grant.
REQ-013 wbm_we_o / wbm_cyc_o / wbm_stb_o  output  1 each  shared bus control; we 0 on instruction grant.
REQ-014 wbm_ack_i / wbm_err_i  input  1 each  shared bus ack/error; read data is routed outside this block.

Function
REQ-015 States IDLE, IGNT, DGNT (one-hot); the grant is registered, so a request seen in IDLE reaches the bus one cycle later.
REQ-016 In IDLE with both requesting (cyc&stb), the master not served last is granted; with one requesting, that one is granted; otherwise stay IDLE.
REQ-017 Bus outputs mux combinationally from the owner; wbm_cyc_o/wbm_stb_o = owner cyc/stb; in IDLE all bus outputs are 0.
REQ-018 wbm_ack_i/wbm_err_i are forwarded combinationally only to the owner; the non-owner's ack/err are always 0.
REQ-019 On owner ack or err, go to IDLE next cycle and record the owner as last served; an owner holding cyc high re-arbitrates against the other master.
REQ-020 If the owner drops cyc with no ack (fetch abort), wbm_cyc_o drops in the same cycle and the arbiter goes to IDLE.
REQ-021 Ack/err arriving in IDLE is discarded and forwarded to no one.
REQ-022 Address, data, sel and we are not registered; latency added per transfer is exactly one arbitration cycle.

Reset
REQ-023 rst_ni low at a clock edge forces IDLE, last-served = instruction (data wins the first tie) and watchdog = 0.
REQ-024 While in IDLE after reset, wbm_cyc_o, wbm_stb_o and all ack/err outputs are 0; reset mid-transaction drops wbm_cyc_o on the next cycle.

Configuration
REQ-025 With ARBITER_TIMEOUT_EN defined, the watchdog counts owner cycles with stb high and no ack/err.
REQ-026 On reaching TIMEOUT, the watchdog pulses owner err_o for one cycle, forces wbm_cyc_o low that cycle and returns the arbiter to IDLE.
REQ-027 Without ARBITER_TIMEOUT_EN, no counter exists and a grant waits indefinitely.

Structure
REQ-028 State encodings and the grant-owner encoding (INSTR=0, DATA=1) live in shared package mirfak_pkg.
REQ-029 The watchdog is sub-module mirfak_arb_timeout (counter width $clog2(TIMEOUT+1), clear, expire pulse), instantiated only under the macro.

Verification
REQ-030 Data-only request, addr 0x8000_0100, we=1, ack on 2nd bus cycle -> wbm_cyc_o high 1 cycle after request, dwb_ack_o one pulse, iwb_ack_o stays 0.
REQ-031 I and D both request from reset -> D granted first; after its ack, I granted next; repeated ties alternate I/D.
REQ-032 Instruction owner drops cyc before ack, then slave acks -> wbm_cyc_o drops the same cycle, the late ack is not forwarded, and the arbiter is in IDLE.
REQ-033 rst_ni low during a DGNT transfer -> after the edge, the arbiter is in IDLE, wbm_cyc_o=0, and dwb_ack_o never asserts.
REQ-034 With ARBITER_TIMEOUT_EN and TIMEOUT=4, slave never acks -> owner err_o pulses once at the 4th stalled cycle, then the other master can be granted.
REQ-035 wbm_err_i on a data transfer -> dwb_err_o one pulse, dwb_ack_o=0, and the arbiter returns to IDLE next cycle.
